mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between two requesters:
  - the instruction-fetch side (I), which feeds the IF stage;
  - the data-cache miss/write-back side (D), driven by the cache.
- Sequences each transfer over a fixed MEM_LAT-cycle memory access, latches the read data, and returns a one-cycle ack to the granted requester.
- Arbitrates simultaneous requests round-robin.
- Exports a busy flag that the pc/pipeline logic uses to freeze the pipeline.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_port_arbiter_arb_rr2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory port arbiter.
package mem_arb_pkg;
    localparam int LANE_W        = 8;
    localparam int LANES_DEFAULT = 4;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    typedef logic [LANES_DEFAULT-1:0][LANE_W-1:0] byte_lanes_t;
endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin grant; the last_grant history register lives in the parent.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt_owner = OWN_I;
        if (req_i && req_d) begin
            gnt_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
        end else if (req_d) begin
            gnt_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between instruction fetch (I) and the data cache (D).
//   state | meaning
//   IDLE  | waiting for a request; arbitration happens here
//   XFER  | memory access in flight, MEM_LAT cycles, latched addr/data driven
//   DONE  | one-cycle ack to the owner, then back to IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 4,
    parameter int LANES   = 4
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [LANES-1:0][LANE_W-1:0]  i_rdata,
    output logic                          i_ack,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [LANES-1:0][LANE_W-1:0]  d_wdata,
    output logic [LANES-1:0][LANE_W-1:0]  d_rdata,
    output logic                          d_ack,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [LANES-1:0][LANE_W-1:0]  mem_data_in,
    input  logic [LANES-1:0][LANE_W-1:0]  mem_data_out,
    output logic                          mem_write_en,
    output logic                          busy
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t                         state_q, state_d;
    owner_t                         owner_q, owner_d;
    owner_t                         last_q, last_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic                           we_q, we_d;
    logic [LANES-1:0][LANE_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0][LANE_W-1:0]   i_rdata_q, i_rdata_d;
    logic [LANES-1:0][LANE_W-1:0]   d_rdata_q, d_rdata_d;
    logic [3:0]                     count_q, count_d;

    logic   gnt_valid;
    owner_t gnt_owner;

    arb_rr2 u_arb (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    last_d  = gnt_owner;
                    addr_d  = (gnt_owner == OWN_I) ? i_addr : d_addr;
                    we_d    = (gnt_owner == OWN_D) && d_we;
                    wdata_d = (gnt_owner == OWN_D) ? d_wdata : '0;
                    count_d = LAT_M1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (count_q == 4'd0) begin
                    state_d = DONE;
                    // Read data is captured on the last access cycle; writes leave rdata alone.
                    if (!we_q) begin
                        if (owner_q == OWN_I) i_rdata_d = mem_data_out;
                        else                  d_rdata_d = mem_data_out;
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_D;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            count_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            count_q   <= count_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign i_ack        = (state_q == DONE) && (owner_q == OWN_I);
    assign d_ack        = (state_q == DONE) && (owner_q == OWN_D);
    assign mem_addr     = (state_q == XFER) ? addr_q : '0;
    assign mem_write_en = (state_q == XFER) && (count_q == 4'd0) && we_q;
    assign mem_data_in  = wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-timeline model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 4;

    logic              clk;
    logic              rst_b;
    logic              i_req;
    logic [31:0]       i_addr;
    logic [3:0][7:0]   i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    byte_lanes_t       d_wdata;
    logic [3:0][7:0]   d_rdata;
    logic              d_ack;
    logic [31:0]       mem_addr;
    logic [3:0][7:0]   mem_data_in;
    logic [3:0][7:0]   mem_data_out;
    logic              mem_write_en;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(LAT), .LANES(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_ack        (i_ack),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h40) return 32'h11223344;
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    assign mem_data_out = mem_rd(mem_addr);

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_pulses, last_wr_cyc;
    logic [31:0] last_wr_data;

    // Model: a transaction is a timeline; m_k counts cycles since the grant edge.
    bit          m_active, m_own_d, m_last_d, m_we;
    int          m_k;
    logic [31:0] m_addr, m_wdata, m_ir, m_dr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (rst_b) begin
            m_active = 0; m_k = 0; m_own_d = 0; m_last_d = 1; m_we = 0;
            m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
        end else if (m_active) begin
            if (m_k == LAT + 1) begin
                m_active = 0;
            end else begin
                if (m_k == LAT && !m_we) begin
                    if (m_own_d) m_dr = mem_rd(m_addr);
                    else         m_ir = mem_rd(m_addr);
                end
                m_k++;
            end
        end else if (i_req || d_req) begin
            if (i_req && d_req) m_own_d = !m_last_d;
            else                m_own_d = d_req;
            m_last_d = m_own_d;
            m_active = 1;
            m_k      = 1;
            m_addr   = m_own_d ? d_addr : i_addr;
            m_we     = m_own_d && d_we;
            m_wdata  = m_own_d ? 32'(d_wdata) : 32'h0;
        end
    endtask

    task automatic compare_all();
        check("busy",         64'(busy),         64'(m_active));
        check("i_ack",        64'(i_ack),        64'(m_active && m_k == LAT + 1 && !m_own_d));
        check("d_ack",        64'(d_ack),        64'(m_active && m_k == LAT + 1 && m_own_d));
        check("mem_addr",     64'(mem_addr),     64'((m_active && m_k <= LAT) ? m_addr : 32'h0));
        check("mem_write_en", 64'(mem_write_en), 64'(m_active && m_k == LAT && m_we));
        check("mem_data_in",  64'(mem_data_in),  64'(m_wdata));
        check("i_rdata",      64'(i_rdata),      64'(m_ir));
        check("d_rdata",      64'(d_rdata),      64'(m_dr));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (mem_write_en === 1'b1) begin
            wr_pulses++;
            last_wr_cyc  = cyc;
            last_wr_data = 32'(mem_data_in);
        end
    endtask

    task automatic wait_any(output int n, output bit got_d);
        n = 0;
        do begin
            step();
            n++;
        end while (!(i_ack === 1'b1 || d_ack === 1'b1) && n < 30);
        check("ack_seen", 64'(i_ack | d_ack), 64'd1);
        got_d = (d_ack === 1'b1);
    endtask

    int n, t0;
    bit got_d;

    initial begin
        rst_b = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        wr_pulses = 0; last_wr_cyc = 0; last_wr_data = '0;
        step(); step();
        rst_b = 0;
        step();

        // I read alone
        i_req = 1; i_addr = 32'h40;
        wait_any(n, got_d);
        check("t1_latency", 64'(n), 64'(LAT + 1));
        check("t1_owner_d", 64'(got_d), 64'd0);
        check("t1_rdata", 64'(i_rdata), 64'h11223344);
        i_req = 0;
        step();

        // D write alone
        wr_pulses = 0;
        t0 = cyc;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hAABBCCDD;
        wait_any(n, got_d);
        d_req = 0; d_we = 0;
        check("t2_latency", 64'(n), 64'(LAT + 1));
        check("t2_owner_d", 64'(got_d), 64'd1);
        check("t2_wr_pulses", 64'(wr_pulses), 64'd1);
        check("t2_wr_cycle", 64'(last_wr_cyc - t0), 64'(LAT));
        check("t2_wr_data", 64'(last_wr_data), 64'hAABBCCDD);
        step();

        // Simultaneous, held high: I, D, I, D
        rst_b = 1; step(); rst_b = 0;
        i_req = 1; i_addr = 32'h500; d_req = 1; d_addr = 32'h600;
        for (int k = 0; k < 4; k++) begin
            wait_any(n, got_d);
            check("t3_gap", 64'(n), 64'((k == 0) ? LAT + 1 : LAT + 2));
            check("t3_owner_d", 64'(got_d), 64'(k % 2));
        end
        i_req = 0; d_req = 0;
        step();

        // D read with address changed mid-transfer
        d_req = 1; d_we = 0; d_addr = 32'h180;
        step(); step();
        d_addr = 32'h200;
        wait_any(n, got_d);
        d_req = 0;
        check("t4_latency", 64'(n + 2), 64'(LAT + 1));
        check("t4_rdata", 64'(d_rdata), 64'(mem_rd(32'h180)));
        step();

        // Reset mid-write
        wr_pulses = 0;
        d_req = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'h01020304;
        step(); step();
        rst_b = 1;
        step();
        rst_b = 0; d_req = 0; d_we = 0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rdata", 64'(d_rdata), 64'd0);
        check("t5_mem_data_in", 64'(mem_data_in), 64'd0);
        for (int k = 0; k < 6; k++) step();
        check("t5_wr_pulses", 64'(wr_pulses), 64'd0);

        // Requester drops i_req mid-transfer
        i_req = 1; i_addr = 32'h44;
        step(); step();
        i_req = 0;
        wait_any(n, got_d);
        check("t6_latency", 64'(n + 2), 64'(LAT + 1));
        check("t6_owner_d", 64'(got_d), 64'd0);
        step();
        check("t6_busy_after", 64'(busy), 64'd0);

        // Randomized traffic, including occasional resets
        for (int k = 0; k < 600; k++) begin
            i_req   = ($urandom_range(0, 3) != 0);
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) != 0;
            i_addr  = $urandom & 32'h0000_0FFC;
            d_addr  = $urandom & 32'h0000_0FFC;
            d_wdata = $urandom;
            rst_b   = ($urandom_range(0, 79) == 0);
            step();
        end
        rst_b = 0; i_req = 0; d_req = 0;
        for (int k = 0; k < 8; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
